gl_cmd_arbiter: RTL and testbench
=================================

GL_CMD_ARBITER -- requirements
Module: gl_cmd_arbiter

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- WIDTH, 32, data/address width.
- MAX_LEN, 16, maximum operand burst length in words.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset. Its ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  reset; asynchronous, active-low.
- host_wr_req  in  1  host command-load write request.
- host_wr_addr  in  WIDTH  write address.
- host_wr_data  in  WIDTH  write data.
- host_wr_gnt  out  1  write accepted this cycle.
- opnd_req  in  1  decode operand burst request.
- opnd_addr  in  WIDTH  burst start address.
- opnd_len  in  5  burst length, 0..MAX_LEN words.
- opnd_gnt  out  1  burst accepted (1-cycle pulse).
- opnd_data  out  WIDTH  operand word.
- opnd_valid  out  1  opnd_data valid.
- opnd_done  out  1  last word delivered (1-cycle pulse).
- fetch_req  in  1  instruction fetch read request.
- fetch_addr  in  WIDTH  fetch address.
- fetch_gnt  out  1  fetch accepted this cycle.
- fetch_data  out  WIDTH  fetched word.
- fetch_valid  out  1  fetch_data valid.
- fetch_stall  out  1  fetch_req pending but not granted.
- bram_addr  out  WIDTH  single-port command BRAM address.
- bram_we  out  1  BRAM write enable.
- bram_din  out  WIDTH  BRAM write data.
- bram_dout  in  WIDTH  BRAM read data; 1-cycle latency.

Function
REQ-003 The block SHALL issue at most one BRAM access per cycle.
REQ-004 In IDLE, grant priority SHALL be host write > operand burst > fetch, evaluated combinationally from same-cycle requests.
REQ-005 A host grant SHALL drive bram_we=1, bram_addr=host_wr_addr, bram_din=host_wr_data, and assert host_wr_gnt in the same cycle.
REQ-006 An operand grant SHALL pulse opnd_gnt, latch opnd_addr and opnd_len, issue the read of opnd_addr in the same cycle, and move to BURST when opnd_len>1.
REQ-007 BURST SHALL issue consecutive reads at addr+1, addr+2, ... one per cycle until opnd_len reads total, then return to IDLE. BURST SHALL NOT be preempted by host or fetch.
REQ-008 opnd_len=0 SHALL pulse opnd_gnt, issue no read, pulse opnd_done the next cycle, and stay in IDLE. opnd_len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-009 Read data SHALL be routed using a 1-cycle-delayed owner tag:
- opnd_valid/fetch_valid assert exactly one cycle after the corresponding grant, with data = bram_dout.
- opnd_done coincides with the last opnd_valid.
REQ-010 A fetch grant SHALL drive bram_addr=fetch_addr and assert fetch_gnt in the same cycle.
REQ-011 fetch_stall SHALL equal fetch_req & ~fetch_gnt.
REQ-012 When nothing is granted, bram_we SHALL be 0 and bram_addr SHALL hold its last value.
REQ-013 Burst address increment SHALL wrap modulo 2^WIDTH.
REQ-014 A request arriving on the same cycle BURST ends SHALL NOT be granted that cycle; it is arbitrated in the next IDLE cycle.

Reset
REQ-015 On reset_n=0 the block SHALL asynchronously enter IDLE and clear every output:
- all gnt, valid, done and stall outputs = 0;
- bram_we = 0; bram_addr = 0; bram_din = 0;
- burst counter and owner tag cleared.
REQ-016 A reset during BURST SHALL abort the burst with no opnd_done and no further valid pulses. The first grant after reset SHALL be possible on the first clk edge with reset_n=1.

Structure
REQ-017 State encodings (IDLE, BURST), owner tag codes (NONE, FETCH, OPND) and MAX_LEN SHALL live in gl_defines.v.
REQ-018 The burst address/length counter SHALL be a sub-module named gl_burst_counter; the remainder stays flat.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Host write at addr 0x10 with data 0xDEADBEEF, concurrent with fetch_req at 0x0: host_wr_gnt=1 and bram_we=1 in cycle 0; fetch_gnt=1 in cycle 1.
- opnd_req with addr 0x20, len 4, while fetch_req is held: reads 0x20..0x23 in cycles 0..3; opnd_valid in cycles 1..4; opnd_done in cycle 4; fetch_stall=1 in cycles 0..3; fetch granted in cycle 4.
- opnd_len=0: opnd_gnt in cycle 0, opnd_done in cycle 1, no opnd_valid, no BRAM read.
- Burst at addr 0xFFFFFFFE, len 3: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
- reset_n dropped in cycle 2 of a len-8 burst: all outputs 0 immediately; no opnd_done; fetch granted in the first cycle after release.
- Back-to-back fetches at 0x0..0x3 with no contention: fetch_valid in every cycle 1..4, data matching a preloaded BRAM.

Source files
------------

// File: rtl/gl_cmd_arbiter_pkg.sv
// Shared encodings and helpers for the command BRAM arbiter.
// Arbiter states, read-owner tags and burst length limits.
package gl_cmd_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_OPND  = 2'd2;

    localparam int GL_MAX_LEN = 16;
    localparam int LEN_W      = 5;

    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] len,
        input logic [LEN_W-1:0] max_len
    );
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/gl_burst_counter.sv
// Operand burst address and remaining-length counter.
// Holds the next burst address; last flags the final read.
module gl_burst_counter
    import gl_cmd_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_addr,
    input  logic [LEN_W-1:0] load_len,
    input  logic             step,
    output logic [WIDTH-1:0] addr,
    output logic             last
);

    logic [LEN_W-1:0] rem_q;

    // Load skips the first word, which the arbiter reads at grant time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr  <= '0;
            rem_q <= '0;
        end else if (load) begin
            addr  <= load_addr + WIDTH'(1);
            rem_q <= load_len - LEN_W'(1);
        end else if (step) begin
            addr  <= addr + WIDTH'(1);
            rem_q <= rem_q - LEN_W'(1);
        end
    end

    assign last = (rem_q == LEN_W'(1));

endmodule

// File: rtl/gl_cmd_arbiter.sv
// Single-port command BRAM arbiter: host write, operand burst, fetch.
// Read data is steered by an owner tag delayed one cycle.
module gl_cmd_arbiter
    import gl_cmd_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_LEN = GL_MAX_LEN
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             host_wr_req,
    input  logic [WIDTH-1:0] host_wr_addr,
    input  logic [WIDTH-1:0] host_wr_data,
    output logic             host_wr_gnt,
    input  logic             opnd_req,
    input  logic [WIDTH-1:0] opnd_addr,
    input  logic [4:0]       opnd_len,
    output logic             opnd_gnt,
    output logic [WIDTH-1:0] opnd_data,
    output logic             opnd_valid,
    output logic             opnd_done,
    input  logic             fetch_req,
    input  logic [WIDTH-1:0] fetch_addr,
    output logic             fetch_gnt,
    output logic [WIDTH-1:0] fetch_data,
    output logic             fetch_valid,
    output logic             fetch_stall,
    output logic [WIDTH-1:0] bram_addr,
    output logic             bram_we,
    output logic [WIDTH-1:0] bram_din,
    input  logic [WIDTH-1:0] bram_dout
);

    logic [0:0]       state_q, state_d;
    logic [1:0]       own_q, own_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] addr_q, din_q;
    logic [LEN_W-1:0] len_c;
    logic             cnt_load, cnt_step, cnt_last;
    logic [WIDTH-1:0] cnt_addr;

    assign len_c = clamp_len(opnd_len, LEN_W'(MAX_LEN));

    gl_burst_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (cnt_load),
        .load_addr (opnd_addr),
        .load_len  (len_c),
        .step      (cnt_step),
        .addr      (cnt_addr),
        .last      (cnt_last)
    );

    // Pick one BRAM access per cycle; a running burst owns the port
    always_comb begin
        host_wr_gnt = 1'b0;
        opnd_gnt    = 1'b0;
        fetch_gnt   = 1'b0;
        bram_we     = 1'b0;
        bram_addr   = addr_q;
        own_d       = OWN_NONE;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        cnt_step    = 1'b0;
        state_d     = state_q;
        if (reset_n) begin
            if (state_q == ST_BURST) begin
                bram_addr = cnt_addr;
                own_d     = OWN_OPND;
                cnt_step  = 1'b1;
                if (cnt_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end else if (host_wr_req) begin
                host_wr_gnt = 1'b1;
                bram_we     = 1'b1;
                bram_addr   = host_wr_addr;
            end else if (opnd_req) begin
                opnd_gnt = 1'b1;
                if (len_c == '0) begin
                    done_d = 1'b1;
                end else begin
                    bram_addr = opnd_addr;
                    own_d     = OWN_OPND;
                    if (len_c == LEN_W'(1)) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = ST_BURST;
                    end
                end
            end else if (fetch_req) begin
                fetch_gnt = 1'b1;
                bram_addr = fetch_addr;
                own_d     = OWN_FETCH;
            end
        end
    end

    assign bram_din    = bram_we ? host_wr_data : din_q;
    assign fetch_stall = reset_n & fetch_req & ~fetch_gnt;
    assign opnd_valid  = (own_q == OWN_OPND);
    assign fetch_valid = (own_q == OWN_FETCH);
    assign opnd_done   = done_q;
    assign opnd_data   = opnd_valid ? bram_dout : '0;
    assign fetch_data  = fetch_valid ? bram_dout : '0;

    // State, owner tag, done pulse and held BRAM address/data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            own_q   <= OWN_NONE;
            done_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            done_q  <= done_d;
            addr_q  <= bram_addr;
            if (bram_we) begin
                din_q <= host_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_gl_cmd_arbiter.sv
// Self-checking bench for gl_cmd_arbiter with a BRAM model.
// Directed scenarios followed by a randomized phase against a reference model.
module tb_gl_cmd_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_wr_req;
    logic [31:0] host_wr_addr;
    logic [31:0] host_wr_data;
    logic        host_wr_gnt;
    logic        opnd_req;
    logic [31:0] opnd_addr;
    logic [4:0]  opnd_len;
    logic        opnd_gnt;
    logic [31:0] opnd_data;
    logic        opnd_valid;
    logic        opnd_done;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic [31:0] fetch_data;
    logic        fetch_valid;
    logic        fetch_stall;
    logic [31:0] bram_addr;
    logic        bram_we;
    logic [31:0] bram_din;
    logic [31:0] bram_dout = 32'h0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    // reference model state
    logic [31:0] burst_q[$];
    int          m_own;
    bit          m_last;
    bit          m_zero;
    logic [31:0] m_data;
    logic [31:0] m_addr;
    logic [31:0] m_din;
    int          n_own;
    bit          n_last;
    bit          n_zero;
    bit          from_burst;
    bit e_hg, e_og, e_fg, e_we, e_stall, e_ov, e_fv, e_done;

    // observed values of the last cycle
    logic        ob_hg, ob_og, ob_fg, ob_we, ob_stall, ob_ov, ob_fv, ob_done;
    logic [31:0] ob_addr, ob_odata, ob_fdata;

    gl_cmd_arbiter #(
        .WIDTH   (32),
        .MAX_LEN (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .host_wr_req  (host_wr_req),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_wr_gnt  (host_wr_gnt),
        .opnd_req     (opnd_req),
        .opnd_addr    (opnd_addr),
        .opnd_len     (opnd_len),
        .opnd_gnt     (opnd_gnt),
        .opnd_data    (opnd_data),
        .opnd_valid   (opnd_valid),
        .opnd_done    (opnd_done),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_data   (fetch_data),
        .fetch_valid  (fetch_valid),
        .fetch_stall  (fetch_stall),
        .bram_addr    (bram_addr),
        .bram_we      (bram_we),
        .bram_din     (bram_din),
        .bram_dout    (bram_dout)
    );

    always #5 clk = ~clk;

    // synchronous single-port BRAM, 1-cycle read latency
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr[7:0]] <= bram_din;
        bram_dout <= mem[bram_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        burst_q.delete();
        m_own  = 0;
        m_last = 0;
        m_zero = 0;
        m_data = '0;
        m_addr = '0;
    endtask

    // arbitration rules: burst words first, then host > operand > fetch
    task automatic model_eval();
        int n;
        e_hg = 0; e_og = 0; e_fg = 0; e_we = 0;
        n_own = 0; n_last = 0; n_zero = 0; from_burst = 0;
        e_ov   = (m_own == 2);
        e_fv   = (m_own == 1);
        e_done = (m_own == 2 && m_last) || m_zero;
        if (burst_q.size() > 0) begin
            from_burst = 1;
            m_addr     = burst_q[0];
            n_own      = 2;
            n_last     = (burst_q.size() == 1);
        end else if (host_wr_req) begin
            e_hg   = 1;
            e_we   = 1;
            m_addr = host_wr_addr;
            m_din  = host_wr_data;
        end else if (opnd_req) begin
            e_og = 1;
            n = (int'(opnd_len) > 16) ? 16 : int'(opnd_len);
            if (n == 0) begin
                n_zero = 1;
            end else begin
                m_addr = opnd_addr;
                n_own  = 2;
                n_last = (n == 1);
                for (int k = 1; k < n; k++)
                    burst_q.push_back(opnd_addr + 32'(k));
            end
        end else if (fetch_req) begin
            e_fg   = 1;
            m_addr = fetch_addr;
            n_own  = 1;
        end
        e_stall = fetch_req && !e_fg;
    endtask

    task automatic model_commit();
        if (from_burst) burst_q.delete(0);
        if (e_we) ref_mem[m_addr[7:0]] = m_din;
        m_data = ref_mem[m_addr[7:0]];
        m_own  = n_own;
        m_last = n_last;
        m_zero = n_zero;
    endtask

    // inputs set at posedge+1; outputs checked at posedge+4
    task automatic run_cycle();
        #3;
        model_eval();
        ob_hg = host_wr_gnt; ob_og = opnd_gnt; ob_fg = fetch_gnt;
        ob_we = bram_we; ob_stall = fetch_stall; ob_ov = opnd_valid;
        ob_fv = fetch_valid; ob_done = opnd_done; ob_addr = bram_addr;
        ob_odata = opnd_data; ob_fdata = fetch_data;
        chk("host_wr_gnt", ob_hg, e_hg);
        chk("opnd_gnt", ob_og, e_og);
        chk("fetch_gnt", ob_fg, e_fg);
        chk("bram_we", ob_we, e_we);
        chk("bram_addr", ob_addr, m_addr);
        if (e_we) chk("bram_din", bram_din, m_din);
        chk("fetch_stall", ob_stall, e_stall);
        chk("opnd_valid", ob_ov, e_ov);
        chk("fetch_valid", ob_fv, e_fv);
        chk("opnd_done", ob_done, e_done);
        chk("opnd_data", ob_odata, e_ov ? m_data : 32'h0);
        chk("fetch_data", ob_fdata, e_fv ? m_data : 32'h0);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hg"}, host_wr_gnt, 0);
        chk({tag, "_og"}, opnd_gnt, 0);
        chk({tag, "_fg"}, fetch_gnt, 0);
        chk({tag, "_stall"}, fetch_stall, 0);
        chk({tag, "_ov"}, opnd_valid, 0);
        chk({tag, "_fv"}, fetch_valid, 0);
        chk({tag, "_done"}, opnd_done, 0);
        chk({tag, "_we"}, bram_we, 0);
        chk({tag, "_addr"}, bram_addr, 0);
        chk({tag, "_din"}, bram_din, 0);
        chk({tag, "_odata"}, opnd_data, 0);
        chk({tag, "_fdata"}, fetch_data, 0);
    endtask

    initial begin
        logic [31:0] prev;
        reset_n      = 1'b0;
        host_wr_req  = 0; host_wr_addr = 0; host_wr_data = 0;
        opnd_req     = 0; opnd_addr = 0; opnd_len = 0;
        fetch_req    = 0; fetch_addr = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        model_reset();
        #1;
        fetch_req = 1;
        chk_all_zero("reset");
        fetch_req = 0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // host write beats a concurrent fetch
        host_wr_req = 1; host_wr_addr = 32'h10; host_wr_data = 32'hDEADBEEF;
        fetch_req = 1; fetch_addr = 32'h0;
        run_cycle();
        chk("s1_host_gnt", ob_hg, 1);
        chk("s1_we", ob_we, 1);
        chk("s1_fetch_wait", ob_fg, 0);
        host_wr_req = 0;
        run_cycle();
        chk("s1_fetch_gnt", ob_fg, 1);
        fetch_req = 0;
        run_cycle();
        chk("s1_fetch_valid", ob_fv, 1);

        // len-4 burst holds off a pending fetch
        opnd_req = 1; opnd_addr = 32'h20; opnd_len = 5'd4;
        fetch_req = 1; fetch_addr = 32'h4;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            opnd_req = 0;
            if (c < 4) chk("s2_addr", ob_addr, 32'h20 + 32'(c));
            chk("s2_stall", ob_stall, 32'(c < 4));
            chk("s2_valid", ob_ov, 32'(c >= 1));
            chk("s2_done", ob_done, 32'(c == 4));
            chk("s2_fetch_gnt", ob_fg, 32'(c == 4));
        end
        fetch_req = 0;
        run_cycle();

        // zero-length burst
        prev = ob_addr;
        opnd_req = 1; opnd_addr = 32'h55; opnd_len = 5'd0;
        run_cycle();
        chk("s3_gnt", ob_og, 1);
        chk("s3_no_read", ob_addr, prev);
        chk("s3_done_early", ob_done, 0);
        opnd_req = 0;
        run_cycle();
        chk("s3_done", ob_done, 1);
        chk("s3_no_valid", ob_ov, 0);
        run_cycle();
        chk("s3_no_valid2", ob_ov, 0);

        // address wrap
        opnd_req = 1; opnd_addr = 32'hFFFFFFFE; opnd_len = 5'd3;
        run_cycle();
        chk("s4_addr0", ob_addr, 32'hFFFFFFFE);
        opnd_req = 0;
        run_cycle();
        chk("s4_addr1", ob_addr, 32'hFFFFFFFF);
        run_cycle();
        chk("s4_addr2", ob_addr, 32'h0);
        run_cycle();
        chk("s4_done", ob_done, 1);

        // back-to-back fetches from preloaded BRAM
        for (int c = 0; c < 5; c++) begin
            fetch_req  = (c < 4);
            fetch_addr = 32'(c);
            run_cycle();
            if (c >= 1) begin
                chk("s6_valid", ob_fv, 1);
                chk("s6_data", ob_fdata, mem[c-1]);
            end
        end
        fetch_req = 0;
        run_cycle();

        // reset in cycle 2 of a len-8 burst
        opnd_req = 1; opnd_addr = 32'h40; opnd_len = 5'd8;
        fetch_req = 1; fetch_addr = 32'h8;
        run_cycle();
        opnd_req = 0;
        run_cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("s5_rst");
        model_reset();
        @(posedge clk); #1;
        chk("s5_rst_done", opnd_done, 0);
        chk("s5_rst_valid", opnd_valid, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_cycle();
        chk("s5_fetch_first", ob_fg, 1);
        chk("s5_no_done", ob_done, 0);
        fetch_req = 0;
        run_cycle();
        chk("s5_no_done2", ob_done, 0);
        chk("s5_fetch_valid", ob_fv, 1);

        // randomized traffic, including over-length bursts and wrap
        for (int i = 0; i < 400; i++) begin
            host_wr_req  = ($urandom_range(0, 3) == 0);
            host_wr_addr = $urandom_range(0, 255);
            host_wr_data = $urandom();
            opnd_req     = ($urandom_range(0, 3) == 0);
            opnd_addr    = ($urandom_range(0, 7) == 0) ?
                           32'hFFFFFFF8 + $urandom_range(0, 7) :
                           $urandom_range(0, 255);
            opnd_len     = 5'($urandom_range(0, 20));
            fetch_req    = ($urandom_range(0, 1) == 1);
            fetch_addr   = $urandom_range(0, 255);
            run_cycle();
        end
        host_wr_req = 0; opnd_req = 0; fetch_req = 0;
        for (int i = 0; i < 20; i++) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
